// File: rtl/instr_mem_loader.sv
// instr_mem_loader: 64 x 16-bit instruction memory with a byte-stream program
// loader. The image is a length byte N (1..64) followed by 2N data bytes, high
// byte first, written sequentially from address 0. cpu_hold keeps the CPU in
// reset whenever the loader is not idle.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader (
  input  logic        clk_main,
  input  logic        reset,
  input  logic [5:0]  PC,
  output logic [15:0] InstructIn,
  input  logic        load_start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [6:0]  load_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [15:0] mem_r [0:63];
  logic [5:0]  addr_r;
  logic [6:0]  len_r;
  logic [7:0]  hi_r;
  logic [6:0]  load_count_r;
  logic        byte_ready_r;
  logic        cpu_hold_r;
  logic        load_done_r;
  logic        load_error_r;
  logic        byte_ready_next_s;
  logic        accept_s;
  logic        start_s;
  logic        wr_en_s;
  logic        len_bad_s;
  logic        last_word_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;

  // Running XOR checksum step over the image bytes.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    csum_step = acc ^ b;
  endfunction
`endif

  assign accept_s    = byte_valid && byte_ready_r;
  assign start_s     = load_start && ((state_r == ST_IDLE) || (state_r == ST_ERR));
  assign wr_en_s     = accept_s && (state_r == ST_LO);
  assign len_bad_s   = (byte_in == 8'd0) || (byte_in > 8'd64);
  assign last_word_s = ((load_count_r + 7'd1) == len_r);

  assign InstructIn  = mem_r[PC];
  assign byte_ready  = byte_ready_r;
  assign cpu_hold    = cpu_hold_r;
  assign load_done   = load_done_r;
  assign load_error  = load_error_r;
  assign load_count  = load_count_r;

  // FSM state register.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; the loader waits in place whenever no byte is accepted.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) state_next_s = ST_LEN;
        else            state_next_s = ST_IDLE;
      end
      ST_LEN: begin
        if (accept_s) begin
          if (len_bad_s) state_next_s = ST_ERR;
          else           state_next_s = ST_HI;
        end else begin
          state_next_s = ST_LEN;
        end
      end
      ST_HI: begin
        if (accept_s) state_next_s = ST_LO;
        else          state_next_s = ST_HI;
      end
      ST_LO: begin
        if (accept_s) begin
          if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
            state_next_s = ST_CSUM;
`else
            state_next_s = ST_DONE;
`endif
          end else begin
            state_next_s = ST_HI;
          end
        end else begin
          state_next_s = ST_LO;
        end
      end
      ST_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept_s) begin
          if (byte_in == csum_r) state_next_s = ST_DONE;
          else                   state_next_s = ST_ERR;
        end else begin
          state_next_s = ST_CSUM;
        end
`else
        state_next_s = ST_IDLE;
`endif
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_ERR: begin
        if (load_start) state_next_s = ST_LEN;
        else            state_next_s = ST_ERR;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake readiness for the upcoming state, so byte_ready can be registered.
  always_comb begin
    byte_ready_next_s = 1'b0;
    case (state_next_s)
      ST_LEN, ST_HI, ST_LO, ST_CSUM: byte_ready_next_s = 1'b1;
      default:                       byte_ready_next_s = 1'b0;
    endcase
  end

  // Registered status outputs, decoded from the state being entered.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      byte_ready_r <= 1'b0;
      cpu_hold_r   <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      byte_ready_r <= byte_ready_next_s;
      cpu_hold_r   <= (state_next_s != ST_IDLE);
      load_done_r  <= (state_next_s == ST_DONE);
      load_error_r <= (state_next_s == ST_ERR);
    end
  end

  // Loader datapath: length, high byte, write address, word count, checksum.
  always_ff @(posedge clk_main) begin
    if (reset) begin
      addr_r       <= 6'd0;
      len_r        <= 7'd0;
      hi_r         <= 8'd0;
      load_count_r <= 7'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else if (start_s) begin
      addr_r       <= 6'd0;
      load_count_r <= 7'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
      csum_r <= csum_step(csum_r, byte_in);
`endif
      case (state_r)
        ST_LEN: len_r <= byte_in[6:0];
        ST_HI:  hi_r  <= byte_in;
        ST_LO: begin
          addr_r       <= addr_r + 6'd1;
          load_count_r <= load_count_r + 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Instruction memory write port; contents survive reset by design.
  always_ff @(posedge clk_main) begin
    if (wr_en_s && !reset) begin
      mem_r[addr_r] <= {hi_r, byte_in};
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and randomized loads
// compared against an array model of the instruction memory.
module tb_instr_mem_loader;

  logic        clk_main = 1'b0;
  logic        reset;
  logic [5:0]  PC;
  logic [15:0] InstructIn;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [6:0]  load_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [64];
  logic [15:0] w_arr [64];
  logic [7:0]  img_q [$];
  logic [7:0]  csum_flip = 8'h00;

  instr_mem_loader dut (
    .clk_main   (clk_main),
    .reset      (reset),
    .PC         (PC),
    .InstructIn (InstructIn),
    .load_start (load_start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .load_count (load_count)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Image = length byte, then nw words high byte first, plus checksum when enabled.
  task automatic make_image(input logic [7:0] len, input int nw);
    logic [7:0] x;
    img_q.delete();
    img_q.push_back(len);
    x = len;
    for (int i = 0; i < nw; i++) begin
      img_q.push_back(w_arr[i][15:8]);
      img_q.push_back(w_arr[i][7:0]);
      x = x ^ w_arr[i][15:8] ^ w_arr[i][7:0];
    end
`ifdef LOADER_CHECKSUM_EN
    if (nw > 0) img_q.push_back(x ^ csum_flip);
`endif
  endtask

  task automatic start_load();
    @(negedge clk_main);
    load_start = 1'b1;
    @(negedge clk_main);
    load_start = 1'b0;
    chk("hold_rise", cpu_hold, 1);
    chk("ready_len", byte_ready, 1);
    chk("count_clr", load_count, 0);
  endtask

  // mode 0: valid always high, 1: toggling, 2: random
  task automatic push_bytes(input int mode);
    int idx = 0;
    int cyc = 0;
    int hold_lost = 0;
    logic v;
    while (idx < img_q.size() && cyc < 1000) begin
      @(negedge clk_main);
      cyc++;
      if (!cpu_hold) hold_lost++;
      if (mode == 1)      v = ((cyc % 2) == 1);
      else if (mode == 2) v = 1'($urandom_range(0, 1));
      else                v = 1'b1;
      byte_valid = v;
      byte_in    = img_q[idx];
      if (v && byte_ready) idx++;
    end
    chk("stream_consumed", idx, img_q.size());
    chk("hold_during_load", hold_lost, 0);
  endtask

  task automatic finish_load(input bit ok, input int n);
    int dn = 0;
    int hold_in_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_main);
      byte_valid = 1'b0;
      if (load_done) begin
        dn++;
        if (cpu_hold) hold_in_done++;
      end
    end
    if (ok) begin
      chk("done_pulses", dn, 1);
      chk("hold_in_done", hold_in_done, 1);
      chk("hold_after", cpu_hold, 0);
      chk("err_ok", load_error, 0);
      chk("ready_idle", byte_ready, 0);
    end else begin
      chk("done_none", dn, 0);
      chk("err_set", load_error, 1);
      chk("hold_err", cpu_hold, 1);
      chk("ready_err", byte_ready, 0);
    end
    chk("load_count", load_count, n);
  endtask

  task automatic model_write(input int n);
    for (int i = 0; i < n; i++) mem_m[i] = w_arr[i];
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 64; i++) begin
      PC = 6'(i);
      #1;
      chk(tag, InstructIn, mem_m[i]);
    end
  endtask

  task automatic rand_words(input int n);
    for (int i = 0; i < n; i++) w_arr[i] = 16'($urandom);
  endtask

  task automatic run_valid(input int n, input int mode);
    make_image(8'(n), n);
    start_load();
    push_bytes(mode);
    finish_load(1'b1, n);
    model_write(n);
  endtask

  initial begin
    reset = 1'b1; PC = 6'd0; load_start = 1'b0; byte_in = 8'd0; byte_valid = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 16'hxxxx;
    repeat (3) @(negedge clk_main);
    reset = 1'b0;
    @(negedge clk_main);
    chk("rst_ready", byte_ready, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_error, 0);
    chk("rst_count", load_count, 0);
    repeat (3) @(negedge clk_main);
    chk("idle_hold", cpu_hold, 0);

    // Fill the whole memory (N=64 boundary) so the model is fully known.
    rand_words(64);
    run_valid(64, 0);
    check_mem("mem_full");

    // Directed N=2 image.
    w_arr[0] = 16'h1234; w_arr[1] = 16'hABCD;
    run_valid(2, 0);
    check_mem("mem_n2");

    // Bad length bytes: no writes, ERR held.
    make_image(8'h00, 0);
    start_load(); push_bytes(0); finish_load(1'b0, 0);
    check_mem("mem_len0");
    make_image(8'h41, 0);
    start_load(); push_bytes(0); finish_load(1'b0, 0);
    check_mem("mem_len41");

    // Recovery from ERR.
    rand_words(5);
    run_valid(5, 0);
    check_mem("mem_recover");

    // Stalled N=3.
    rand_words(3);
    run_valid(3, 1);
    check_mem("mem_stall3");

    // Random loads with random stalls.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 64));
      rand_words(n);
      run_valid(n, 2);
    end
    check_mem("mem_random");

    // Reset after the first word of an N=4 load.
    rand_words(4);
    make_image(8'd4, 1);
    img_q = img_q[0:2];
    start_load();
    push_bytes(0);
    @(negedge clk_main);
    byte_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk_main);
    reset = 1'b0;
    chk("midrst_hold", cpu_hold, 0);
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_err", load_error, 0);
    chk("midrst_count", load_count, 0);
    model_write(1);
    check_mem("mem_midrst");

`ifdef LOADER_CHECKSUM_EN
    w_arr[0] = 16'h8000;
    csum_flip = 8'h00;
    run_valid(1, 0);
    check_mem("mem_csum_ok");
    w_arr[0] = 16'h8000;
    csum_flip = 8'hFE;
    make_image(8'd1, 1);
    chk("csum_byte", img_q[3], 8'h7F);
    start_load(); push_bytes(0); finish_load(1'b0, 1);
    model_write(1);
    check_mem("mem_csum_bad");
    csum_flip = 8'h00;
    rand_words(2);
    run_valid(2, 2);
    check_mem("mem_csum_recover");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
